// File: rtl/alu_seq_divider.sv
// Multi-cycle restoring divider (quotient/remainder) with start/busy/done handshake.
// Optional two's-complement mode enabled by defining ALU_DIV_SIGNED_EN.
module alu_seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_sel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] bus_out
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] acc;      // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             fin;
    logic             dz;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

`ifdef ALU_DIV_SIGNED_EN
    logic fix;
    logic neg_q;
    logic neg_r;

    assign dvd_mag = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    always_comb begin
        shifted = {rem, acc[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    assign bus_out = div_sel ? quotient : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            acc       <= '0;
            rem       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            fin       <= 1'b0;
            dz        <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
            fix       <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    state <= StIdle;
                    if (start) begin
                        state <= StCalc;
                        busy  <= 1'b1;
                        acc   <= dvd_mag;
                        dvs   <= dvs_mag;
                        // Divide-by-zero skips the steps; rem carries the raw dividend out.
                        rem   <= (divisor == '0) ? dividend : '0;
                        dz    <= (divisor == '0);
                        fin   <= (divisor == '0);
                        cnt   <= CW'(WIDTH - 1);
`ifdef ALU_DIV_SIGNED_EN
                        fix   <= 1'b0;
                        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividend[WIDTH-1];
`endif
                    end
                end
                StCalc: begin
                    if (!fin) begin
                        acc <= {acc[WIDTH-2:0], ~trial[WIDTH]};
                        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        if (cnt == '0) begin
                            fin <= 1'b1;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
`ifdef ALU_DIV_SIGNED_EN
                    else if (!fix && !dz) begin
                        acc <= neg_q ? ({WIDTH{1'b0}} - acc) : acc;
                        rem <= neg_r ? ({WIDTH{1'b0}} - rem) : rem;
                        fix <= 1'b1;
                    end
`endif
                    else begin
                        state     <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        div_zero  <= dz;
                        quotient  <= dz ? '1 : acc;
                        remainder <= rem;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/alu_seq_divider.md
Name: alu_seq_divider

Overview:
- Multi-cycle restoring divider for the 8-bit datapath ALU.
- Performs the inverse of the single-cycle multiplier: quotient and remainder from dividend and divisor.
- Uses a start/busy/done handshake, since division cannot finish in one cycle at the target clock.
- Results drive the shared ALU result bus through an output-enabled path, alongside the add and multiply units.

Parameters:
WIDTH, 8, operand/result width in bits (min 2).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE or DONE
dividend  in  WIDTH  numerator, captured on accepted start
divisor  in  WIDTH  denominator, captured on accepted start
div_sel  in  1  result bus enable; high drives quotient onto bus_out, else bus_out = 0
busy  out  1  high while a division is in progress
done  out  1  one-cycle pulse: results valid
div_zero  out  1  divisor was 0 for the last completed operation
quotient  out  WIDTH  held result
remainder  out  WIDTH  held result
bus_out  out  WIDTH  gated quotient for the shared ALU result bus

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and reset.
- Reset: state=IDLE; busy, done, div_zero = 0; quotient, remainder = 0.
- Reset mid-operation aborts the operation immediately; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE: start=1 captures operands.
  - divisor != 0: go to CALC with iteration count = WIDTH-1.
  - divisor == 0: go to DONE directly.
- CALC: one restoring step per cycle.
  - Shift partial remainder left by 1, bringing in the next dividend MSB.
  - Trial subtract divisor (WIDTH+1-bit arithmetic). If non-negative, keep the difference and the quotient bit is 1; else restore and the quotient bit is 0.
  - After WIDTH steps, go to DONE.
- DONE: lasts one cycle, then returns to IDLE.
  - done=1; quotient, remainder and div_zero are updated and held until the next completion.
  - start=1 in DONE is accepted, so the next operation begins with no idle gap.
- busy=1 in CALC, and in the cycle after an accepted start. busy=0 in IDLE and DONE.
- Latency, divisor != 0: start accepted at edge k; done high during the cycle after edge k+WIDTH+1, i.e. 9 cycles for WIDTH=8.
- Latency, divisor == 0: done in the cycle after edge k+1.
- Divide by zero: quotient = all ones; remainder = dividend; div_zero=1.
- start while busy is ignored. Operand changes while busy have no effect.
- Unsigned by default.
- bus_out is combinational: div_sel ? quotient : 0, so outputs can be OR-combined with the other ALU units.

Optional Feature:
- Macro: ALU_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Divide the magnitudes, then correct signs.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case (most-negative / -1): quotient = most-negative, remainder = 0.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Latency increases by exactly 1 cycle (sign-fix stage before DONE).
- Undefined: unsigned only; no extra cycle or logic.

Test Plan:
- Unsigned divide: reset, start with dividend=200, divisor=7 -> busy for 9 cycles, done pulse; quotient=28, remainder=4, div_zero=0.
- Divide by zero: dividend=5, divisor=0 -> done 1 cycle after start; quotient=0xFF, remainder=5, div_zero=1.
- Small dividend, then back-to-back: dividend=13, divisor=200 -> quotient=0, remainder=13. Hold start high into DONE with 255/1 -> next done 9 cycles later, quotient=255, remainder=0.
- Start while busy: pulse start again mid-CALC with 9/3 -> ignored; first result unchanged, exactly one done pulse.
- Reset mid-operation: assert reset at CALC step 4 -> next cycle busy=0, outputs 0, no done. A following 100/10 gives quotient=10, remainder=0.
- Bus gating and signed mode: div_sel=0 -> bus_out=0; div_sel=1 -> bus_out=quotient. With ALU_DIV_SIGNED_EN: -100/7 -> quotient=-14 (0xF2), remainder=-2 (0xFE), done after 10 cycles; -128/-1 -> quotient=0x80, remainder=0.
